// File: rtl/dpram_arb.sv
// dpram_arb: shares the write-capable port B of the I/D dual-port RAM
// between the load/store unit (m0) and a secondary bus master (m1).
// m0 has fixed priority. m1 is forced ahead once it has been refused
// MAX_WAIT cycles in a row. Each response is steered back to its issuer.
//
// rsp_st    | meaning
// ----------+-----------------------------------------------
// RSP_IDLE  | no access was accepted last cycle, no response
// RSP_M0    | m0 access accepted last cycle, m0_rvalid high
// RSP_M1    | m1 access accepted last cycle, m1_rvalid high
module dpram_arb #(
   parameter int ADDR_W   = 11,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [3:0]        m0_wem,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [31:0]       m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [31:0]       m0_rdata,

   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [3:0]        m1_wem,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [31:0]       m1_rdata,

   output logic              ram_enb,
   output logic              ram_web,
   output logic [3:0]        ram_wemb,
   output logic [ADDR_W-1:0] ram_addrb,
   output logic [31:0]       ram_dinb,
   input  logic [31:0]       ram_doutb
);

   typedef enum logic [1:0] {
      RSP_IDLE = 2'd0,
      RSP_M0   = 2'd1,
      RSP_M1   = 2'd2
   } rsp_st_t;

   localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

   rsp_st_t     r_rsp_st;
   rsp_st_t     w_rsp_nxt;
   logic [3:0]  r_starve_cnt;
   logic        w_force_m1;

   // m1 has waited its limit: it overrides m0 for this one cycle
   assign w_force_m1 = m1_req && (r_starve_cnt == LP_MAX_WAIT);

   // Grant decision and port B mux; everything is quiet while in reset
   always_comb begin
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      ram_enb   = 1'b0;
      ram_web   = 1'b0;
      ram_wemb  = 4'b0000;
      ram_addrb = '0;
      ram_dinb  = 32'h0;
      if (rst_n) begin
         if (w_force_m1) begin
            m1_gnt = 1'b1;
         end else if (m0_req) begin
            m0_gnt = 1'b1;
         end else if (m1_req) begin
            m1_gnt = 1'b1;
         end
      end
      if (m0_gnt) begin
         ram_enb   = 1'b1;
         ram_web   = m0_we;
         ram_wemb  = m0_we ? m0_wem : 4'b0000;
         ram_addrb = m0_addr;
         ram_dinb  = m0_wdata;
      end else if (m1_gnt) begin
         ram_enb   = 1'b1;
         ram_web   = m1_we;
         ram_wemb  = m1_we ? m1_wem : 4'b0000;
         ram_addrb = m1_addr;
         ram_dinb  = m1_wdata;
      end
   end

   // Count consecutive refusals of m1; a grant or a dropped request restarts it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_starve_cnt <= 4'd0;
      end else if (m1_gnt || !m1_req) begin
         r_starve_cnt <= 4'd0;
      end else if (r_starve_cnt != LP_MAX_WAIT) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end

   // Next response owner is simply whoever was accepted this cycle
   always_comb begin
      w_rsp_nxt = RSP_IDLE;
      if (m0_req && m0_gnt) begin
         w_rsp_nxt = RSP_M0;
      end else if (m1_req && m1_gnt) begin
         w_rsp_nxt = RSP_M1;
      end
   end

   // Response state register; reset drops any pending response
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rsp_st <= RSP_IDLE;
      end else begin
         r_rsp_st <= w_rsp_nxt;
      end
   end

   assign m0_rvalid = (r_rsp_st == RSP_M0);
   assign m1_rvalid = (r_rsp_st == RSP_M1);
   assign m0_rdata  = m0_rvalid ? ram_doutb : 32'h0;
   assign m1_rdata  = m1_rvalid ? ram_doutb : 32'h0;

endmodule

// File: doc/dpram_arb.md
# dpram_arb

Two-requester arbiter for the write-capable port B of the instruction/data dual-port RAM. It shares that port between the core load/store unit (m0) and a secondary bus master such as the debug module or a DMA (m1). Port A stays dedicated to instruction fetch. Arbitration is fixed-priority with a bounded-starvation override, throughput is one access per cycle, and each response is routed back to its issuing requester.

## Interface
Parameters:
- ADDR_W, 11 — word-address width; equals clogb2(RAM_DEPTH-1) of the attached RAM (2048 words).
- MAX_WAIT, 4 — consecutive cycles m1 may be refused before it is forced ahead of m0; legal range 1..15.

Ports:
- clk  in  1  — single clock; every register is clocked on its rising edge.
- rst_n  in  1  — reset, synchronous and active-low.
- mX_req  in  1  — access request, X = 0 or 1; must hold with stable payload until granted.
- mX_we  in  1  — 1 = write, 0 = read.
- mX_wem  in  4  — byte strobes; bit i selects byte [8i+7:8i]; ignored on reads.
- mX_addr  in  ADDR_W  — word address.
- mX_wdata  in  32  — write data.
- mX_gnt  out  1  — combinational; the access is accepted in a cycle where req && gnt.
- mX_rvalid  out  1  — response pulse, one cycle after acceptance.
- mX_rdata  out  32  — read data, valid only while mX_rvalid is high.
- ram_enb  out  1  — port B enable.
- ram_web  out  1  — port B write enable.
- ram_wemb  out  4  — port B byte strobes.
- ram_addrb  out  ADDR_W  — port B address.
- ram_dinb  out  32  — port B write data.
- ram_doutb  in  32  — port B registered read data (1-cycle latency, read-first).

## Operation
Grant logic (combinational):
- When rst_n is low, m0_gnt = m1_gnt = 0.
- When starve_cnt == MAX_WAIT and m1_req is high, m1 is granted.
- Otherwise, m0 is granted if m0_req is high, and m1 is granted if m1_req is high and m0_req is low.
- At most one grant is high in any cycle.

RAM drive:
- ram_enb = m0_gnt | m1_gnt.
- ram_web = granted master's we.
- ram_wemb = granted master's wem when we = 1, else 4'b0000.
- ram_addrb and ram_dinb come from the granted master; they are 0 when no grant is active.

Starvation counter, starve_cnt (4 bits):
- Reset value 0.
- Increments when m1_req is high and m1_gnt is low.
- Saturates at MAX_WAIT.
- Clears to 0 when m1_gnt is high or m1_req is low.

Response FSM (register rsp_st):
- States: RSP_IDLE, RSP_M0, RSP_M1.
- Every cycle, rsp_st becomes RSP_M0 if m0 was accepted, RSP_M1 if m1 was accepted, and RSP_IDLE otherwise.
- Any state can move to any other in one cycle, so back-to-back accesses from either master are fully pipelined.

Response outputs:
- mX_rvalid = (rsp_st == RSP_MX).
- mX_rdata = ram_doutb when mX_rvalid is high, else 32'h0.
- rvalid pulses for writes as well and acts as a write acknowledge. rdata then carries the old word (read-first) and requesters must ignore it.

Boundary conditions:
- Simultaneous m0 and m1 requests with starve_cnt < MAX_WAIT: m0 wins and the counter increments.
- m1 forced: m0 is refused for exactly one cycle, then normal priority resumes.
- m1_req dropped before it is granted: this is a protocol violation; the counter clears and no access occurs.
- Reset asserted mid-access: the pending response is discarded, with no rvalid on the next cycle. rsp_st goes to RSP_IDLE and starve_cnt to 0. The RAM contents are not affected beyond an access already clocked into the RAM.

## Timing
- Reset values (in the cycle after clk sampling rst_n = 0):
  - rsp_st = RSP_IDLE and starve_cnt = 0.
  - All rvalid outputs are 0 and all rdata outputs are 0.
  - All gnt and ram_* outputs are 0 while rst_n is low.
- The request-to-grant path is combinational, in the same cycle.
- Request-to-response latency is exactly 1 cycle after acceptance, for both reads and writes.
- Peak throughput is one access per cycle on port B.
- Worst-case m1 wait under continuous m0 traffic is MAX_WAIT cycles, so m1 is granted on the (MAX_WAIT+1)-th cycle of requesting.
- There are no combinational paths from ram_doutb to any RAM-side output.

## Test plan
- **Read after write, m0:** m0 writes 0xDEADBEEF with wem = 4'hF to addr 0x010. Then m0 reads addr 0x010. Required: the write-ack rvalid at cycle t+1, and the read response carries m0_rdata = 0xDEADBEEF with m0_rvalid one cycle after its grant.
- **Byte strobes:** m1 writes 0x11223344 with wem = 4'b0101 to a word holding 0xAAAAAAAA. Then m1 reads that word. Required: m1_rdata = 0xAA22AA44.
- **Simultaneous requests:** both masters request reads on the same cycle from addr 0x001 and 0x002. Required: m0 is granted first, m1 is granted the next cycle, and each rvalid pulses only on its own port with correct data.
- **Starvation:** m0_req held high continuously and m1_req held high with MAX_WAIT = 4. Required: m1_gnt rises on the 5th cycle, m0_gnt is low in that cycle only, and starve_cnt returns to 0 afterwards.
- **Pipelining:** alternating m0/m1 reads on every cycle over 8 cycles. Required: 8 consecutive rvalid pulses alternating between ports with no bubbles.
- **Reset mid-access:** assert rst_n = 0 in the cycle an m0 read is accepted. Required: m0_rvalid = 0 on the following cycle, all outputs at their reset values, and normal operation on the first cycle after release.
